// File: rtl/bam_pkg.sv
// Shared constants and types for the bam control path: opcodes, funct codes,
// ALU select encodings and the sequencer state enum.
package bam_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_STI   = 6'b101011;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } stateT;

endpackage

// File: rtl/bam_decode.sv
// Purely combinational instruction classifier for the bam control path.
// Kept separate so a future pipelined sequencer can reuse it unchanged.
module bam_decode
  import bam_pkg::*;
(
  input  logic [31:0] instrData,
  output logic        isRtype,
  output logic        isStore,
  output logic        isIllegal,
  output logic [3:0]  aluSel
);

  logic [5:0] opcode;
  logic [5:0] funct;
  // Operand fields are consumed by the sequencer, not by the classifier.
  logic       unusedFields;

  assign opcode       = instrData[31:26];
  assign funct        = instrData[5:0];
  assign unusedFields = ^instrData[25:6];

  // Classify the word and map the funct field onto an ALU select.
  always_comb begin
    isRtype   = 1'b0;
    isStore   = 1'b0;
    isIllegal = 1'b1;
    aluSel    = ALU_AND;
    if (opcode == OP_RTYPE) begin
      isRtype   = 1'b1;
      isIllegal = 1'b0;
      case (funct)
        FN_AND:  aluSel = ALU_AND;
        FN_OR:   aluSel = ALU_OR;
        FN_ADD:  aluSel = ALU_ADD;
        FN_SUB:  aluSel = ALU_SUB;
        FN_SLT:  aluSel = ALU_SLT;
        FN_NOR:  aluSel = ALU_NOR;
        default: begin
          isRtype   = 1'b0;
          isIllegal = 1'b1;
        end
      endcase
    end else if (opcode == OP_STI) begin
      isStore   = 1'b1;
      isIllegal = 1'b0;
    end
  end

endmodule

// File: rtl/bam_sequencer.sv
// Multi-cycle control stage feeding the bam datapath. Accepts one instruction
// word at a time, walks it through DECODE/EXEC/WB and drives the register,
// ALU and data-memory controls, plus debug counters and a sticky error flag.
module bam_sequencer
  import bam_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instrValid,
  input  logic [31:0]        instrData,
  output logic               instrReady,
  input  logic               bamZf,
  output logic [4:0]         bamRA1,
  output logic [4:0]         bamRA2,
  output logic [4:0]         bamDirB,
  output logic [3:0]         bamSel,
  output logic               bamRegWrite,
  output logic               bamwr,
  output logic [4:0]         bamDir,
  output logic [31:0]        bamDi,
  output logic               busy,
  output logic               illegal,
  output logic [COUNT_W-1:0] instrCount,
  output logic [COUNT_W-1:0] zeroCount
);

  // EXEC holds for EXEC_CYCLES cycles, so the down-counter starts one below.
  localparam logic [3:0]         EXEC_LOAD = 4'(EXEC_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  stateT       state;
  logic [31:0] instrWord;
  logic        wordIsR;
  logic [3:0]  execCnt;

  logic        decRtype;
  logic        decStore;
  logic        decIllegal;
  logic [3:0]  decSel;

  bam_decode uDecode (
    .instrData (instrWord),
    .isRtype   (decRtype),
    .isStore   (decStore),
    .isIllegal (decIllegal),
    .aluSel    (decSel)
  );

  // Sequencer FSM with every output registered; write strobes default low
  // so they can only ever last the single WB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instrWord   <= '0;
      wordIsR     <= 1'b0;
      execCnt     <= '0;
      instrReady  <= 1'b0;
      bamRA1      <= '0;
      bamRA2      <= '0;
      bamDirB     <= '0;
      bamSel      <= '0;
      bamRegWrite <= 1'b0;
      bamwr       <= 1'b0;
      bamDir      <= '0;
      bamDi       <= '0;
      busy        <= 1'b0;
      illegal     <= 1'b0;
      instrCount  <= '0;
      zeroCount   <= '0;
    end else begin
      bamRegWrite <= 1'b0;
      bamwr       <= 1'b0;
      case (state)
        IDLE: begin
          if (instrValid && instrReady) begin
            instrWord  <= instrData;
            instrReady <= 1'b0;
            busy       <= 1'b1;
            state      <= DECODE;
          end else begin
            instrReady <= 1'b1;
          end
        end
        DECODE: begin
          if (decIllegal) begin
            illegal    <= 1'b1;
            busy       <= 1'b0;
            instrReady <= 1'b1;
            state      <= IDLE;
          end else if (decRtype) begin
            bamRA1  <= instrWord[25:21];
            bamRA2  <= instrWord[20:16];
            bamSel  <= decSel;
            execCnt <= EXEC_LOAD;
            wordIsR <= 1'b1;
            state   <= EXEC;
          end else if (decStore) begin
            bamDir  <= instrWord[20:16];
            bamDi   <= {16'h0000, instrWord[15:0]};
            bamwr   <= 1'b1;
            wordIsR <= 1'b0;
            state   <= WB;
          end
        end
        EXEC: begin
          if (execCnt == 4'd0) begin
            bamDirB     <= instrWord[15:11];
            bamRegWrite <= (instrWord[15:11] != 5'd0);
            state       <= WB;
          end else begin
            execCnt <= execCnt - 4'd1;
          end
        end
        WB: begin
          busy       <= 1'b0;
          instrReady <= 1'b1;
          state      <= IDLE;
          if (instrCount != CNT_MAX) begin
            instrCount <= instrCount + CNT_ONE;
          end
          if (wordIsR && bamZf && (zeroCount != CNT_MAX)) begin
            zeroCount <= zeroCount + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bam_sequencer.sv
// Scoreboard bench for bam_sequencer: each accepted word that should produce
// a write strobe pushes its expected strobe; a negedge monitor pops and checks.
module tb_bam_sequencer;

  localparam int MAX_CNT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrValid;
  logic [31:0] instrData;
  logic        instrReady;
  logic        bamZf;
  logic [4:0]  bamRA1;
  logic [4:0]  bamRA2;
  logic [4:0]  bamDirB;
  logic [3:0]  bamSel;
  logic        bamRegWrite;
  logic        bamwr;
  logic [4:0]  bamDir;
  logic [31:0] bamDi;
  logic        busy;
  logic        illegal;
  logic [1:0]  instrCount;
  logic [1:0]  zeroCount;

  typedef struct {
    bit          isReg;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [3:0]  sel;
    int          cyc;
  } pulseT;

  pulseT sbQ[$];
  pulseT monE;
  int    regPulseCycles[$];
  int    cycle = 0;
  int    checks = 0;
  int    errors = 0;
  int    modelInstr = 0;
  int    modelZero = 0;
  bit    modelIllegal = 1'b0;

  bam_sequencer #(.EXEC_CYCLES(1), .COUNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .instrValid  (instrValid),
    .instrData   (instrData),
    .instrReady  (instrReady),
    .bamZf       (bamZf),
    .bamRA1      (bamRA1),
    .bamRA2      (bamRA2),
    .bamDirB     (bamDirB),
    .bamSel      (bamSel),
    .bamRegWrite (bamRegWrite),
    .bamwr       (bamwr),
    .bamDir      (bamDir),
    .bamDi       (bamDi),
    .busy        (busy),
    .illegal     (illegal),
    .instrCount  (instrCount),
    .zeroCount   (zeroCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference decode written straight from the instruction set table.
  function automatic void modelWord(input logic [31:0] w, output bit legal, output bit isR,
                                    output logic [3:0] sel);
    legal = 1'b0;
    isR   = 1'b0;
    sel   = 4'b0000;
    if (w[31:26] == 6'b000000) begin
      case (w[5:0])
        6'b100100: begin legal = 1'b1; sel = 4'b0000; end
        6'b100101: begin legal = 1'b1; sel = 4'b0001; end
        6'b100000: begin legal = 1'b1; sel = 4'b0010; end
        6'b100010: begin legal = 1'b1; sel = 4'b0110; end
        6'b101010: begin legal = 1'b1; sel = 4'b0111; end
        6'b100111: begin legal = 1'b1; sel = 4'b1100; end
        default:   legal = 1'b0;
      endcase
      isR = legal;
    end else if (w[31:26] == 6'b101011) begin
      legal = 1'b1;
    end
  endfunction

  // Present a word, wait for the accepting edge and record what it should do.
  task automatic applyStimulus(input logic [31:0] word, input logic zf, input bit holdValid);
    bit         legal;
    bit         isR;
    bit         ok;
    logic [3:0] sel;
    pulseT      e;
    modelWord(word, legal, isR, sel);
    instrData  = word;
    instrValid = 1'b1;
    bamZf      = zf;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (instrReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    checkOutput("acceptWait", 64'(ok), 64'd1);
    if (ok) begin
      if (legal) begin
        if (modelInstr < MAX_CNT) modelInstr++;
        if (isR && zf && modelZero < MAX_CNT) modelZero++;
        if (!isR || word[15:11] != 5'd0) begin
          e.isReg = isR;
          e.addr  = isR ? word[15:11] : word[20:16];
          e.data  = isR ? 32'h0 : {16'h0000, word[15:0]};
          e.ra1   = word[25:21];
          e.ra2   = word[20:16];
          e.sel   = sel;
          e.cyc   = cycle + (isR ? 3 : 2);
          sbQ.push_back(e);
        end
      end else begin
        modelIllegal = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!holdValid) instrValid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0 && instrReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("idleWait", 64'(ok), 64'd1);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".instrCount"}, 64'(instrCount), 64'(modelInstr));
    checkOutput({tag, ".zeroCount"}, 64'(zeroCount), 64'(modelZero));
    checkOutput({tag, ".illegal"}, 64'(illegal), 64'(modelIllegal));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ctrl"}, 64'({instrReady, busy, illegal, bamRegWrite, bamwr, instrCount, zeroCount}), 64'd0);
    checkOutput({tag, ".addr"}, 64'({bamRA1, bamRA2, bamDirB, bamSel, bamDir}), 64'd0);
    checkOutput({tag, ".data"}, 64'(bamDi), 64'd0);
  endtask

  // Strobe monitor: every strobe must match the oldest expected one.
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (bamRegWrite === 1'b1 && bamwr === 1'b1) begin
      checkOutput("bothStrobes", 64'({bamRegWrite, bamwr}), 64'd0);
    end
    if (bamRegWrite === 1'b1 || bamwr === 1'b1) begin
      if (bamRegWrite === 1'b1) regPulseCycles.push_back(cycle);
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedStrobe", 64'({bamRegWrite, bamwr}), 64'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("strobeKind", 64'({bamRegWrite, bamwr}), monE.isReg ? 64'd2 : 64'd1);
        checkOutput("strobeCycle", 64'(cycle), 64'(monE.cyc));
        if (monE.isReg) begin
          checkOutput("regWrite", 64'({bamDirB, bamRA1, bamRA2, bamSel}),
                      64'({monE.addr, monE.ra1, monE.ra2, monE.sel}));
        end else begin
          checkOutput("memWrite", 64'({bamDir, bamDi}), 64'({monE.addr, monE.data}));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    instrValid = 1'b1;
    instrData  = 32'h02EC6820;
    bamZf      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkAllZero("reset");
    instrValid = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("readyAfterRst", 64'({instrReady, busy}), 64'd2);

    // ADD r13 = r23 + r12
    applyStimulus(32'h02EC6820, 1'b0, 1'b0);
    waitIdle();
    checkCounters("add");

    // Undecodable opcode, then an R-type with an unmapped funct
    applyStimulus(32'hFC000000, 1'b0, 1'b0);
    waitIdle();
    checkCounters("illOpcode");
    applyStimulus(32'h00000001, 1'b0, 1'b0);
    waitIdle();
    checkCounters("illFunct");

    // Store-immediate 456 to address 5
    applyStimulus(32'hAC0501C8, 1'b0, 1'b0);
    waitIdle();
    checkCounters("store");

    // Reset in the middle of EXEC with a word still offered
    instrData  = 32'h02EC6820;
    instrValid = 1'b1;
    bamZf      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    checkOutput("execBeforeRst", 64'({busy, instrReady}), 64'd2);
    rst = 1'b1;
    #1;
    checkAllZero("asyncRst");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("noXferInRst", 64'({instrReady, busy}), 64'd0);
    instrValid   = 1'b0;
    rst          = 1'b0;
    modelInstr   = 0;
    modelZero    = 0;
    modelIllegal = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("readyAfterRst2", 64'({instrReady, busy}), 64'd2);

    // SUB then AND with instrValid held high across both
    regPulseCycles.delete();
    applyStimulus(32'h01E77022, 1'b0, 1'b1);
    applyStimulus(32'h00270824, 1'b0, 1'b0);
    waitIdle();
    checkCounters("b2b");
    checkOutput("b2bStrobes", 64'(regPulseCycles.size()), 64'd2);
    if (regPulseCycles.size() == 2) begin
      checkOutput("b2bSpacing", 64'(regPulseCycles[1] - regPulseCycles[0]), 64'd4);
    end

    // rd = 0: no register write but still counted
    applyStimulus(32'h00430020, 1'b0, 1'b0);
    waitIdle();
    checkCounters("rdZero");

    // Zero flag high during WB; counters run into saturation
    applyStimulus(32'h00A63825, 1'b1, 1'b0);
    waitIdle();
    checkCounters("orZf");
    applyStimulus(32'h01095027, 1'b1, 1'b0);
    waitIdle();
    checkCounters("norZf");
    applyStimulus(32'h0164602A, 1'b1, 1'b0);
    waitIdle();
    checkCounters("sltZf");

    repeat (3) @(negedge clk);
    #1;
    checkOutput("pendingStrobes", 64'(sbQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
